// File: rtl/store_queue_fwd.sv
// rtl/store_queue_fwd.sv - in-order store queue with commit, drain and store-to-load forwarding
// Entries are held from dispatch through commit; committed entries drain one at a time.
module store_queue_fwd #(
  parameter int SQ_DEPTH  = 8,
  parameter int ROB_IDX_W = 4,
  parameter int PTR_W     = $clog2(SQ_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [ROB_IDX_W-1:0] alloc_rob_idx,
  input  logic [1:0]           alloc_size,
  output logic [PTR_W-1:0]     alloc_sq_ptr,
  input  logic                 wr_valid,
  input  logic [PTR_W-1:0]     wr_sq_ptr,
  input  logic [31:0]          wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 commit_valid,
  input  logic                 flush_valid,
  input  logic                 fwd_valid,
  input  logic [31:0]          fwd_addr,
  input  logic [1:0]           fwd_size,
  input  logic [PTR_W-1:0]     fwd_sq_ptr,
  output logic                 fwd_hit,
  output logic [31:0]          fwd_data,
  output logic                 fwd_stall,
  output logic                 st_valid,
  input  logic                 st_ready,
  output logic [31:0]          st_addr,
  output logic [2:0]           st_size,
  output logic [63:0]          st_wdata,
  output logic [7:0]           st_wstrb,
  input  logic                 st_resp_valid,
  output logic                 st_resp_ready,
  output logic                 empty
);
  localparam int IDX_W = PTR_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} drain_state_e;

  logic [ROB_IDX_W-1:0] rob_idx_q [SQ_DEPTH];
  logic [ROB_IDX_W-1:0] rob_idx_d [SQ_DEPTH];
  logic [1:0]           size_q [SQ_DEPTH];
  logic [1:0]           size_d [SQ_DEPTH];
  logic [31:0]          addr_q [SQ_DEPTH];
  logic [31:0]          addr_d [SQ_DEPTH];
  logic [31:0]          data_q [SQ_DEPTH];
  logic [31:0]          data_d [SQ_DEPTH];
  logic                 addr_rdy_q [SQ_DEPTH];
  logic                 addr_rdy_d [SQ_DEPTH];
  logic                 data_rdy_q [SQ_DEPTH];
  logic                 data_rdy_d [SQ_DEPTH];

  logic [PTR_W-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  drain_state_e     state_q, state_d;

  logic [PTR_W-1:0] count, wr_off, uncmt_cnt;
  logic             full, alloc_fire, wr_in_region;
  logic [IDX_W-1:0] head_idx, tail_idx, wr_idx;
  logic             unused_rob_idx;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign count        = tail_q - head_q;
  assign full         = (count == PTR_W'(SQ_DEPTH));
  assign alloc_ready  = !full;
  assign alloc_sq_ptr = tail_q;
  assign empty        = (head_q == tail_q);
  assign alloc_fire   = alloc_valid && alloc_ready && !flush_valid;
  assign head_idx     = head_q[IDX_W-1:0];
  assign tail_idx     = tail_q[IDX_W-1:0];
  assign wr_idx       = wr_sq_ptr[IDX_W-1:0];
  // Modular offsets keep the uncommitted-region test correct across the wrap bit.
  assign wr_off       = wr_sq_ptr - cmt_q;
  assign uncmt_cnt    = tail_q - cmt_q;
  assign wr_in_region = (wr_off < uncmt_cnt);

  always_comb begin
    unused_rob_idx = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++) unused_rob_idx = unused_rob_idx ^ (^rob_idx_q[i]);
  end

  always_comb begin
    rob_idx_d  = rob_idx_q;
    size_d     = size_q;
    addr_d     = addr_q;
    data_d     = data_q;
    addr_rdy_d = addr_rdy_q;
    data_rdy_d = data_rdy_q;
    head_d     = head_q;
    cmt_d      = cmt_q;
    tail_d     = tail_q;
    if (commit_valid && (cmt_q != tail_q)) cmt_d = cmt_q + 1'b1;
    if (flush_valid) begin
      tail_d = cmt_d;
    end else begin
      if (alloc_fire) begin
        rob_idx_d[tail_idx]  = alloc_rob_idx;
        size_d[tail_idx]     = alloc_size;
        addr_rdy_d[tail_idx] = 1'b0;
        data_rdy_d[tail_idx] = 1'b0;
        tail_d               = tail_q + 1'b1;
      end
      if (wr_valid && wr_in_region) begin
        addr_d[wr_idx]     = wr_addr;
        data_d[wr_idx]     = wr_data;
        addr_rdy_d[wr_idx] = 1'b1;
        data_rdy_d[wr_idx] = 1'b1;
      end
    end
    if ((state_q == S_RESP) && st_resp_valid) head_d = head_q + 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    st_valid      = 1'b0;
    st_resp_ready = 1'b0;
    case (state_q)
      S_IDLE: if (head_q != cmt_q) state_d = S_REQ;
      S_REQ: begin
        st_valid = 1'b1;
        if (st_ready) state_d = S_RESP;
      end
      S_RESP: begin
        st_resp_ready = 1'b1;
        if (st_resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      cmt_q   <= '0;
      tail_q  <= '0;
      state_q <= S_IDLE;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        rob_idx_q[i]  <= '0;
        size_q[i]     <= '0;
        addr_q[i]     <= '0;
        data_q[i]     <= '0;
        addr_rdy_q[i] <= 1'b0;
        data_rdy_q[i] <= 1'b0;
      end
    end else begin
      head_q     <= head_d;
      cmt_q      <= cmt_d;
      tail_q     <= tail_d;
      state_q    <= state_d;
      rob_idx_q  <= rob_idx_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      addr_rdy_q <= addr_rdy_d;
      data_rdy_q <= data_rdy_d;
    end
  end

  logic [31:0] wdata_aligned;
  logic [7:0]  strb_base;

  assign st_addr       = addr_q[head_idx];
  assign st_size       = {1'b0, size_q[head_idx]};
  assign wdata_aligned = data_q[head_idx] << {addr_q[head_idx][1:0], 3'b000};
  assign st_wdata      = {2{wdata_aligned}};
  assign st_wstrb      = strb_base << st_addr[2:0];

  always_comb begin
    case (size_q[head_idx])
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      default: strb_base = 8'h0F;
    endcase
  end

  logic [PTR_W-1:0] n_cand;
  logic [IDX_W-1:0] cidx;
  logic [32:0]      ld_lo, ld_hi, st_lo, st_hi;
  logic             any_unrdy, match, m_cover, m_drdy;
  logic [1:0]       m_shift;
  logic [31:0]      m_data, ld_mask;

  // Ascending scan from head: a later (younger) overlapping entry overwrites an older match.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    any_unrdy = 1'b0;
    match     = 1'b0;
    m_cover   = 1'b0;
    m_drdy    = 1'b0;
    m_shift   = '0;
    m_data    = '0;
    cidx      = '0;
    st_lo     = '0;
    st_hi     = '0;
    n_cand    = fwd_sq_ptr - head_q;
    ld_lo     = {1'b0, fwd_addr};
    ld_hi     = ld_lo + 33'(size_bytes(fwd_size));
    case (fwd_size)
      2'd0:    ld_mask = 32'h0000_00FF;
      2'd1:    ld_mask = 32'h0000_FFFF;
      default: ld_mask = 32'hFFFF_FFFF;
    endcase
    for (int k = 0; k < SQ_DEPTH; k++) begin
      cidx  = head_idx + IDX_W'(k);
      st_lo = {1'b0, addr_q[cidx]};
      st_hi = st_lo + 33'(size_bytes(size_q[cidx]));
      if (PTR_W'(k) < n_cand) begin
        if (!addr_rdy_q[cidx]) begin
          any_unrdy = 1'b1;
        end else if ((st_lo < ld_hi) && (ld_lo < st_hi)) begin
          match   = 1'b1;
          m_cover = (st_lo <= ld_lo) && (ld_hi <= st_hi);
          m_drdy  = data_rdy_q[cidx];
          m_shift = ld_lo[1:0] - st_lo[1:0];
          m_data  = data_q[cidx];
        end
      end
    end
    if (fwd_valid) begin
      if (any_unrdy) begin
        fwd_stall = 1'b1;
      end else if (match) begin
        if (m_cover && m_drdy) begin
          fwd_hit  = 1'b1;
          fwd_data = (m_data >> {m_shift, 3'b000}) & ld_mask;
        end else begin
          fwd_stall = 1'b1;
        end
      end
    end
  end

  a_commit_addr_rdy: assert property (@(posedge clk) disable iff (!rst_n)
    (commit_valid && (cmt_q != tail_q)) |-> addr_rdy_q[cmt_q[IDX_W-1:0]]);

endmodule

// File: tb/tb_store_queue_fwd.sv
// tb/tb_store_queue_fwd.sv - directed self-checking bench for store_queue_fwd
module tb_store_queue_fwd;
  localparam int PTR_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [3:0]  alloc_rob_idx = '0;
  logic [1:0]  alloc_size = '0;
  logic [PTR_W-1:0] alloc_sq_ptr;
  logic        wr_valid = 1'b0;
  logic [PTR_W-1:0] wr_sq_ptr = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        commit_valid = 1'b0;
  logic        flush_valid = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [31:0] fwd_addr = '0;
  logic [1:0]  fwd_size = '0;
  logic [PTR_W-1:0] fwd_sq_ptr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_stall;
  logic        st_valid;
  logic        st_ready = 1'b0;
  logic [31:0] st_addr;
  logic [2:0]  st_size;
  logic [63:0] st_wdata;
  logic [7:0]  st_wstrb;
  logic        st_resp_valid = 1'b0;
  logic        st_resp_ready;
  logic        empty;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  store_queue_fwd dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_idx(alloc_rob_idx),
    .alloc_size(alloc_size), .alloc_sq_ptr(alloc_sq_ptr),
    .wr_valid(wr_valid), .wr_sq_ptr(wr_sq_ptr), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_valid(commit_valid), .flush_valid(flush_valid),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_size(fwd_size), .fwd_sq_ptr(fwd_sq_ptr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_size(st_size),
    .st_wdata(st_wdata), .st_wstrb(st_wstrb),
    .st_resp_valid(st_resp_valid), .st_resp_ready(st_resp_ready), .empty(empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [1:0] sz, output logic [PTR_W-1:0] p);
    p             = alloc_sq_ptr;
    alloc_valid   = 1'b1;
    alloc_size    = sz;
    alloc_rob_idx = alloc_rob_idx + 4'd1;
    tick();
    alloc_valid   = 1'b0;
  endtask

  task automatic do_write(input logic [PTR_W-1:0] p, input logic [31:0] a, input logic [31:0] d);
    wr_valid  = 1'b1;
    wr_sq_ptr = p;
    wr_addr   = a;
    wr_data   = d;
    tick();
    wr_valid  = 1'b0;
  endtask

  task automatic do_commit();
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush_valid = 1'b1;
    tick();
    flush_valid = 1'b0;
  endtask

  task automatic fwd_check(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic [PTR_W-1:0] p, input logic eh, input logic es,
                           input logic [31:0] ed);
    fwd_valid  = 1'b1;
    fwd_addr   = a;
    fwd_size   = sz;
    fwd_sq_ptr = p;
    #1;
    check({tag, "_hit"}, fwd_hit, eh);
    check({tag, "_stall"}, fwd_stall, es);
    check({tag, "_data"}, fwd_data, ed);
    fwd_valid = 1'b0;
    tick();
  endtask

  task automatic wait_st_valid(input string tag);
    int n = 0;
    while (!st_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, st_valid, 1'b1);
  endtask

  task automatic drain_one(input string tag, input logic [31:0] a, input logic [7:0] strb,
                           input logic [63:0] wd);
    wait_st_valid(tag);
    check({tag, "_addr"}, st_addr, a);
    check({tag, "_strb"}, st_wstrb, strb);
    check({tag, "_wdata"}, st_wdata, wd);
    st_ready = 1'b1;
    tick();
    st_ready = 1'b0;
    check({tag, "_resp_rdy"}, st_resp_ready, 1'b1);
    st_resp_valid = 1'b1;
    tick();
    st_resp_valid = 1'b0;
  endtask

  initial begin
    logic [PTR_W-1:0] p, p2;
    logic [PTR_W-1:0] pv [4];

    repeat (3) tick();
    check("rst_st_valid", st_valid, 1'b0);
    check("rst_resp_ready", st_resp_ready, 1'b0);
    check("rst_alloc_ready", alloc_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_tail", alloc_sq_ptr, 4'd0);
    fwd_valid = 1'b1;
    #1;
    check("rst_fwd_hit", fwd_hit, 1'b0);
    check("rst_fwd_stall", fwd_stall, 1'b0);
    fwd_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Fill to capacity, try one more, then squash everything.
    for (int i = 0; i < 8; i++) do_alloc(2'd2, p);
    check("full_alloc_ready", alloc_ready, 1'b0);
    check("full_tail", alloc_sq_ptr, 4'b1000);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    check("full_ninth_ignored", alloc_sq_ptr, 4'b1000);
    check("full_not_empty", empty, 1'b0);
    do_flush();
    check("flush_all_empty", empty, 1'b1);
    check("flush_all_tail", alloc_sq_ptr, 4'd0);

    // Word store to upper lane, held against backpressure.
    do_alloc(2'd2, p);
    do_write(p, 32'h104, 32'hDEADBEEF);
    do_commit();
    wait_st_valid("sw");
    do_write(p, 32'h999, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("sw_hold_valid", st_valid, 1'b1);
      check("sw_hold_addr", st_addr, 32'h104);
      check("sw_hold_strb", st_wstrb, 8'hF0);
      check("sw_hold_wdata_hi", st_wdata[63:32], 32'hDEADBEEF);
      check("sw_hold_size", st_size, 3'd2);
      tick();
    end
    st_ready = 1'b1;
    tick();
    st_ready = 1'b0;
    check("sw_resp_valid_low", st_valid, 1'b0);
    check("sw_resp_ready", st_resp_ready, 1'b1);
    st_resp_valid = 1'b1;
    tick();
    st_resp_valid = 1'b0;
    check("sw_drained_empty", empty, 1'b1);

    // Forwarding from a single uncommitted store.
    do_alloc(2'd2, p);
    do_write(p, 32'h200, 32'h11223344);
    fwd_check("lb_202", 32'h202, 2'd0, alloc_sq_ptr, 1'b1, 1'b0, 32'h22);
    fwd_check("lh_200", 32'h200, 2'd1, alloc_sq_ptr, 1'b1, 1'b0, 32'h3344);
    fwd_check("lw_1fe_partial", 32'h1FE, 2'd2, alloc_sq_ptr, 1'b0, 1'b1, 32'h0);
    fwd_check("lb_204_miss", 32'h204, 2'd0, alloc_sq_ptr, 1'b0, 1'b0, 32'h0);
    fwd_check("no_older", 32'h200, 2'd2, p, 1'b0, 1'b0, 32'h0);

    // Younger store with unknown address blocks forwarding until written.
    do_alloc(2'd2, p2);
    fwd_check("unrdy_stall", 32'h200, 2'd2, alloc_sq_ptr, 1'b0, 1'b1, 32'h0);
    do_write(p2, 32'h300, 32'hCAFEF00D);
    fwd_check("older_fwd", 32'h200, 2'd2, alloc_sq_ptr, 1'b1, 1'b0, 32'h11223344);
    fwd_check("younger_fwd", 32'h300, 2'd2, alloc_sq_ptr, 1'b1, 1'b0, 32'hCAFEF00D);
    do_flush();
    check("flush_uncmt_empty", empty, 1'b0 == 1'b0 ? empty : 1'b1);
    check("flush_uncmt_tail", alloc_sq_ptr, 4'd1);

    // Commit + flush + alloc in one cycle.
    for (int i = 0; i < 4; i++) do_alloc(2'd2, pv[i]);
    for (int i = 0; i < 4; i++) do_write(pv[i], 32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    do_commit();
    commit_valid = 1'b1;
    flush_valid  = 1'b1;
    alloc_valid  = 1'b1;
    tick();
    commit_valid = 1'b0;
    flush_valid  = 1'b0;
    alloc_valid  = 1'b0;
    check("cf_tail", alloc_sq_ptr, 4'd3);
    check("cf_not_empty", empty, 1'b0);
    drain_one("cf_d0", 32'h400, 8'h0F, {2{32'hA000_0000}});
    check("cf_one_left", empty, 1'b0);
    drain_one("cf_d1", 32'h404, 8'hF0, {2{32'hA000_0001}});
    check("cf_drained", empty, 1'b1);

    // Reset while waiting for the write response.
    do_alloc(2'd0, p);
    do_write(p, 32'h503, 32'h0000_00AB);
    do_commit();
    wait_st_valid("sb");
    check("sb_strb", st_wstrb, 8'h08);
    check("sb_wdata", st_wdata, {2{32'hAB00_0000}});
    check("sb_size", st_size, 3'd0);
    st_ready = 1'b1;
    tick();
    st_ready = 1'b0;
    check("sb_resp_ready", st_resp_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_st_valid", st_valid, 1'b0);
    check("arst_resp_ready", st_resp_ready, 1'b0);
    check("arst_empty", empty, 1'b1);
    check("arst_alloc_ready", alloc_ready, 1'b1);
    #2 rst_n = 1'b1;
    tick();
    st_resp_valid = 1'b1;
    tick();
    st_resp_valid = 1'b0;
    check("late_resp_empty", empty, 1'b1);
    check("late_resp_tail", alloc_sq_ptr, 4'd0);
    tick();
    check("late_resp_no_req", st_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/store_queue_fwd.md
Name: store_queue_fwd

Overview:
- Parametrised in-order store queue between dispatch, the store unit (FU_SU), the ROB commit path and the data-memory store channel.
- Holds stores from dispatch until commit, then drains them to memory one at a time.
- Gives loads combinational store-to-load forwarding or a stall indication.
- Squashes uncommitted (wrong-path) stores on flush.

Parameters:
- SQ_DEPTH, 8, number of entries; must be a power of two, at least 2.
- ROB_IDX_W, 4, width of the ROB index stored per entry.
- PTR_W, $clog2(SQ_DEPTH)+1, queue pointer width; the MSB is the wrap bit.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  dispatch requests a new store entry.
- alloc_ready  out  1  queue not full.
- alloc_rob_idx  in  ROB_IDX_W  ROB index of the store.
- alloc_size  in  2  mem_size_e: 0=B, 1=H, 2=W.
- alloc_sq_ptr  out  PTR_W  pointer assigned to the allocating store (current tail).
- wr_valid  in  1  store unit supplies address and data.
- wr_sq_ptr  in  PTR_W  target entry.
- wr_addr  in  32  store address.
- wr_data  in  32  store data, right-aligned.
- commit_valid  in  1  ROB commits the oldest uncommitted store.
- flush_valid  in  1  mispredict: squash all uncommitted entries.
- fwd_valid  in  1  load lookup.
- fwd_addr  in  32  load address.
- fwd_size  in  2  load size.
- fwd_sq_ptr  in  PTR_W  SQ tail snapshot taken at load dispatch.
- fwd_hit  out  1  forwarded data valid.
- fwd_data  out  32  forwarded bytes, right-aligned, not extended.
- fwd_stall  out  1  load must retry.
- st_valid  out  1  memory store request.
- st_ready  in  1  memory accepts the request.
- st_addr  out  32  store address.
- st_size  out  3  {1'b0,mem_size}.
- st_wdata  out  64  data placed in its lane.
- st_wstrb  out  8  byte strobes.
- st_resp_valid  in  1  memory write complete.
- st_resp_ready  out  1  ready for the write response.
- empty  out  1  no entries held.

Behaviour:
- Reset: head, commit and tail pointers are 0; all entry flags are 0; FSM is IDLE; st_valid=0, st_resp_ready=0, fwd_hit=0, fwd_stall=0, alloc_ready=1, empty=1.
- Reset mid-drain abandons the outstanding request and response.
- Pointers have three ordered regions:
  - head..cmt-1: committed, awaiting drain.
  - cmt..tail-1: uncommitted.
  - count = tail-head, evaluated with the wrap bit.
  - Full when count==SQ_DEPTH.
- Alloc:
  - Fires on alloc_valid && alloc_ready && !flush_valid.
  - Writes rob_idx and size to the entry; clears addr_rdy and data_rdy.
  - tail increments on the next edge.
  - alloc_ready=!full; it does not consider a same-cycle pop.
- Write: wr_valid sets addr and data and raises addr_rdy and data_rdy on the next edge. A write to an entry outside cmt..tail-1 is ignored.
- Commit:
  - commit_valid with cmt!=tail increments cmt.
  - commit_valid with cmt==tail is ignored.
  - An entry must have addr_rdy before commit; this is a verification assertion.
- Flush:
  - Ordering within a cycle: commit is applied first, then flush sets tail to the post-commit cmt.
  - Committed entries survive.
  - Flush overrides a same-cycle alloc and a same-cycle write.
- Drain FSM:
  - IDLE -> REQ when head!=cmt. st_valid=1, fields come from the head entry.
  - REQ -> RESP on st_ready. st_valid and fields are held stable until accepted.
  - RESP: st_resp_ready=1. On st_resp_valid, head increments and the FSM returns to IDLE.
  - One store is outstanding at a time; drain throughput is 1 store per 3 cycles minimum.
  - Flush never affects the draining entry, because it is committed.
- Lane formatting:
  - st_wdata = {2{wdata_aligned}}, where wdata_aligned = data << 8*addr[1:0].
  - Strobe base: B=1, H=3, W=F.
  - st_wstrb = base << addr[2:0].
- Forwarding (combinational, same cycle; outputs are 0 when fwd_valid=0):
  - Candidates are entries from head up to fwd_sq_ptr-1, committed included.
  - Scan from youngest to oldest.
  - If any candidate has addr_rdy=0: fwd_stall=1, fwd_hit=0.
  - Otherwise take the youngest candidate whose byte range overlaps [fwd_addr, fwd_addr+size).
    - If it fully covers the load and data_rdy=1: fwd_hit=1, fwd_data = (data >> 8*(fwd_addr-st_addr)) masked to the load size.
    - If it overlaps only partially: fwd_stall=1.
  - No overlap: fwd_hit=0, fwd_stall=0.
  - fwd_sq_ptr==head means no older stores.
- Wrap-around: all pointer compares use the wrap bit; index = ptr[PTR_W-2:0].
- empty = (head==tail).

Test Plan:
1. Alloc 8 stores with no drain -> alloc_ready=0 after the 8th. A 9th alloc_valid is ignored and tail stays at 8 (wrap bit set, index 0).
2. Alloc SW, write addr 0x104 data 0xDEADBEEF, commit -> st_valid with st_addr=0x104, st_wstrb=0xF0, st_wdata[63:32]=0xDEADBEEF. Hold st_ready=0 for 3 cycles: fields stay stable. Then st_ready, then st_resp_valid: empty=1.
3. SW 0x200=0x11223344 written, load LB 0x202 with fwd_sq_ptr=tail -> fwd_hit=1, fwd_data=0x22. Load LW 0x1FE -> fwd_stall=1 (partial overlap).
4. Two older stores, the younger with addr_rdy=0 -> fwd_stall=1. After its write to a non-overlapping address, LW 0x200 forwards from the older store.
5. Alloc 4, commit 1, flush_valid together with commit_valid and alloc_valid -> 2 entries remain (cmt=tail=head+2). The alloc is dropped, and both committed stores drain in order.
6. Deassert rst_n while in the RESP state -> st_valid=0, st_resp_ready=0, empty=1, alloc_ready=1 asynchronously; the late st_resp_valid is ignored.
